// File: rtl/io_keypad.sv
`default_nettype none
// ============================================================================
// Module   : io_keypad
// Purpose  : 5x5 active-low key-matrix scanner with per-key frame debounce.
//            Optional ghost-frame rejection enabled by macro IO_KEYPAD_GHOST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module io_keypad #(
  parameter int SCAN_DIV        = 16384,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  btny,
  output logic [4:0]  btnx,
  output logic [24:0] btn,
  output logic [24:0] btn_press,
  output logic [24:0] btn_release,
  output logic        frame_done
);

  localparam int                SLOT_W      = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] C_SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [4:0]        C_DEB       = 5'(DEBOUNCE_FRAMES);
  localparam logic [2:0]        C_COL_LAST  = 3'd4;

  logic [SLOT_W-1:0] r_slot;
  logic [2:0]        r_col;
  logic [4:0]        r_btnx;
  logic [24:0]       r_raw;
  logic              r_frame_done;
  logic              r_primed;
  logic              w_slot_last;
  logic              w_update;

  assign w_slot_last = (r_slot == C_SLOT_LAST);

  // Column drive rotates as a one-cold register so btnx never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot       <= '0;
      r_col        <= '0;
      r_btnx       <= 5'b11110;
      r_raw        <= '0;
      r_frame_done <= 1'b0;
      r_primed     <= 1'b0;
    end else begin
      r_frame_done <= w_slot_last && (r_col == C_COL_LAST);
      if (r_frame_done) begin
        r_primed <= 1'b1;
      end
      if (w_slot_last) begin
        r_slot <= '0;
        r_col  <= (r_col == C_COL_LAST) ? 3'd0 : r_col + 3'd1;
        r_btnx <= {r_btnx[3:0], r_btnx[4]};
        for (int c = 0; c < 5; c++) begin
          if (r_col == 3'(c)) begin
            r_raw[c*5 +: 5] <= ~btny;
          end
        end
      end else begin
        r_slot <= r_slot + 1'b1;
      end
    end
  end

  assign btnx       = r_btnx;
  assign frame_done = r_frame_done;

`ifdef IO_KEYPAD_GHOST_EN
  // Three pressed corners of any row/column rectangle make the fourth
  // corner ambiguous, so the whole frame is untrustworthy.
  logic w_ghost;

  always_comb begin
    w_ghost = 1'b0;
    for (int c1 = 0; c1 < 4; c1++) begin
      for (int c2 = c1 + 1; c2 < 5; c2++) begin
        for (int r1 = 0; r1 < 4; r1++) begin
          for (int r2 = r1 + 1; r2 < 5; r2++) begin
            if ((r_raw[c1*5+r1] & r_raw[c1*5+r2] & r_raw[c2*5+r1]) |
                (r_raw[c1*5+r1] & r_raw[c1*5+r2] & r_raw[c2*5+r2]) |
                (r_raw[c1*5+r1] & r_raw[c2*5+r1] & r_raw[c2*5+r2]) |
                (r_raw[c1*5+r2] & r_raw[c2*5+r1] & r_raw[c2*5+r2])) begin
              w_ghost = 1'b1;
            end
          end
        end
      end
    end
  end

  assign w_update = r_frame_done && !w_ghost;
`else
  assign w_update = r_frame_done;
`endif

  for (genvar k = 0; k < 25; k++) begin : g_key
    logic [3:0] r_cnt;
    logic       r_btn;
    logic       r_press;
    logic       r_release;
    logic       w_differs;
    logic       w_settled;
    logic [4:0] w_cnt_inc;

    assign w_differs = r_raw[k] ^ r_btn;
    assign w_cnt_inc = {1'b0, r_cnt} + 5'd1;
    // The first frame after reset may count but never toggle a key.
    assign w_settled = r_primed && (w_cnt_inc >= C_DEB);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt     <= '0;
        r_btn     <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        if (w_update) begin
          if (!w_differs) begin
            r_cnt <= '0;
          end else if (w_settled) begin
            r_cnt     <= '0;
            r_btn     <= r_raw[k];
            r_press   <= r_raw[k];
            r_release <= ~r_raw[k];
          end else begin
            r_cnt <= w_cnt_inc[3:0];
          end
        end
      end
    end

    assign btn[k]         = r_btn;
    assign btn_press[k]   = r_press;
    assign btn_release[k] = r_release;
  end

endmodule
`default_nettype wire

// File: tb/tb_io_keypad.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_io_keypad
// Purpose  : Frame-level reference model and randomized key stimulus for io_keypad.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_keypad;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int FRAME    = 5 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  btny;
  logic [4:0]  btnx;
  logic [24:0] btn;
  logic [24:0] btn_press;
  logic [24:0] btn_release;
  logic        frame_done;

  logic [24:0] keys   = '0;
  logic [4:0]  glitch = '0;

  io_keypad #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_FRAMES(DEB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btny       (btny),
    .btnx       (btnx),
    .btn        (btn),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Physical matrix: a held key pulls its row low while its column is driven.
  always_comb begin
    btny = 5'h1f;
    for (int c = 0; c < 5; c++) begin
      if (!btnx[c]) begin
        for (int r = 0; r < 5; r++) begin
          if (keys[c*5+r]) btny[r] = 1'b0;
        end
      end
    end
    btny = btny ^ glitch;
  end

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  logic [24:0] m_btn   = '0;
  logic [24:0] m_press = '0;
  logic [24:0] m_rel   = '0;
  logic [24:0] m_last_frame = '0;
  int          m_cnt [25];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  function automatic bit is_ghost(input logic [24:0] f);
    int n;
    for (int c1 = 0; c1 < 5; c1++)
      for (int c2 = c1 + 1; c2 < 5; c2++)
        for (int r1 = 0; r1 < 5; r1++)
          for (int r2 = r1 + 1; r2 < 5; r2++) begin
            n = int'(f[c1*5+r1]) + int'(f[c1*5+r2]) + int'(f[c2*5+r1]) + int'(f[c2*5+r2]);
            if (n >= 3) return 1'b1;
          end
    return 1'b0;
  endfunction

  // Debounce rule applied once per completed frame of raw key state.
  task automatic model_frame(input logic [24:0] raw, input int frame_idx);
    m_press = '0;
    m_rel   = '0;
`ifdef IO_KEYPAD_GHOST_EN
    if (is_ghost(raw)) return;
`endif
    for (int i = 0; i < 25; i++) begin
      if (raw[i] != m_btn[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] >= DEB && frame_idx > 0) begin
          m_cnt[i] = 0;
          m_btn[i] = raw[i];
          if (raw[i]) m_press[i] = 1'b1;
          else        m_rel[i]   = 1'b1;
        end
      end else begin
        m_cnt[i] = 0;
      end
    end
  endtask

  task automatic model_clear();
    m_btn = '0; m_press = '0; m_rel = '0; m_last_frame = '0;
    for (int i = 0; i < 25; i++) m_cnt[i] = 0;
  endtask

  // Called at the negedge inside cycle k: check that cycle, then drive it.
  task automatic step(input logic [24:0] kv, input bit glitchy);
    logic [4:0] exp_x;
    logic       exp_fd;
    if (k > FRAME && k % FRAME == 1) model_frame(m_last_frame, k / FRAME - 1);
    else begin m_press = '0; m_rel = '0; end
    exp_x  = ~(5'b00001 << ((k / SCAN_DIV) % 5));
    exp_fd = (k > 0) && (k % FRAME == 0);
    check("btnx", {27'd0, btnx}, {27'd0, exp_x});
    check("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
    check("btn", {7'd0, btn}, {7'd0, m_btn});
    check("btn_press", {7'd0, btn_press}, {7'd0, m_press});
    check("btn_release", {7'd0, btn_release}, {7'd0, m_rel});
    keys = kv;
    glitch = (glitchy && (k % SCAN_DIV) != SCAN_DIV - 1) ? 5'($urandom) : 5'd0;
    if (k % FRAME == FRAME - 1) m_last_frame = kv;
    @(negedge clk);
    k++;
  endtask

  task automatic run_frames(input logic [24:0] kv, input int n, input bit glitchy);
    repeat (n * FRAME) step(kv, glitchy);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_btnx"}, {27'd0, btnx}, 32'h1e);
    check({tag, "_btn"}, {7'd0, btn}, 32'd0);
    check({tag, "_press"}, {7'd0, btn_press}, 32'd0);
    check({tag, "_release"}, {7'd0, btn_release}, 32'd0);
    check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    keys = '0;
    glitch = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    k = 0;
    model_clear();
  endtask

  initial begin
    logic [24:0] v;
    model_clear();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_init");
    rst_n = 1'b1;
    k = 0;

    // Key (col 2,row 1) held from reset, then released.
    run_frames(25'd1 << 11, 4, 1'b0);
    run_frames('0, 4, 1'b0);
    // Key 0 press and release.
    run_frames(25'd1, 4, 1'b0);
    run_frames('0, 4, 1'b0);
    // Bounce on key 11: 2 pressed, 1 released, then steady.
    run_frames(25'd1 << 11, 2, 1'b0);
    run_frames('0, 1, 1'b0);
    run_frames(25'd1 << 11, 4, 1'b0);
    run_frames('0, 4, 1'b0);
    // Three rectangle corners pressed together.
    run_frames(25'h0000023, 4, 1'b0);
    run_frames('0, 4, 1'b0);

    // Randomized sparse key sets with row glitches between sample cycles.
    for (int ph = 0; ph < 40; ph++) begin
      v = '0;
      for (int i = 0; i < 25; i++) if ($urandom_range(0, 9) == 0) v[i] = 1'b1;
      run_frames(v, $urandom_range(1, 5), 1'b1);
    end
    run_frames('0, 4, 1'b1);

    // Reset while column 3 is driven and key 24 is part-way through debounce.
    do_reset();
    run_frames(25'd1 << 24, 1, 1'b0);
    repeat (3 * SCAN_DIV + 1) step(25'd1 << 24, 1'b0);
    do_reset();
    run_frames(25'd1 << 24, 4, 1'b0);
    run_frames('0, 4, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_keypad.md
IO_KEYPAD -- requirements
Module: io_keypad

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16384, clock cycles each column is driven (>=2).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 4, consecutive disagreeing frames required to change a debounced key (1..15).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btny  input  5  matrix row returns, active-low (pulled high externally).
REQ-006 SHALL have port btnx  output  5  matrix column drives, active-low, exactly one bit low at any time.
REQ-007 SHALL have port btn  output  25  debounced key state, 1 = pressed, index col*5+row.
REQ-008 SHALL have port btn_press  output  25  one-cycle pulse per key on debounced 0->1.
REQ-009 SHALL have port btn_release  output  25  one-cycle pulse per key on debounced 1->0.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse when a full 5-column frame has been sampled.

Function
REQ-011 SHALL contain a column-slot counter 0..SCAN_DIV-1 and a column index 0..4; the index advances when the counter wraps, and 4 wraps to 0.
REQ-012 SHALL drive btnx low only on the bit equal to the column index; all other bits are high.
REQ-013 SHALL sample ~btny into raw[col*5+4 : col*5] only in the last cycle of the slot (counter = SCAN_DIV-1), so rows get SCAN_DIV-1 cycles to settle.
REQ-014 SHALL pulse frame_done in the cycle after the column-4 sample, and the full 25-bit raw frame is valid in that cycle.
REQ-015 SHALL keep a 4-bit counter per key; on each frame_done, a key with raw != btn increments its counter, and a key with raw == btn clears it.
REQ-016 SHALL toggle btn for a key and clear its counter when the increment reaches DEBOUNCE_FRAMES; btn updates in the frame_done cycle and registers one cycle later.
REQ-017 SHALL assert btn_press or btn_release for exactly the one cycle in which the corresponding btn bit changes.
REQ-018 SHALL handle multiple keys changing in the same frame independently and in parallel.
REQ-019 SHALL hold btn and all counters constant between frame_done pulses, whatever btny does.
REQ-020 SHALL treat a row glitch outside the sample cycle as invisible.
REQ-021 SHALL give an end-to-end latency from a stable press to btn rising of DEBOUNCE_FRAMES frames, plus at most one partial frame, plus one cycle.

Reset
REQ-022 SHALL, while rst_n = 0, force btnx = 5'b11110, set column index and slot counter to 0, and clear raw, btn, all debounce counters, btn_press, btn_release and frame_done.
REQ-023 SHALL, when reset asserts mid-frame, discard the partial frame and start scanning from column 0 slot 0 on the first clk edge after release.
REQ-024 SHALL NOT generate any btn_press pulse in the first frame after reset, even when keys are held.

Configuration
REQ-025 SHALL, when macro IO_KEYPAD_GHOST_EN is defined, discard any raw frame in which three pressed keys form three corners of a row/column rectangle; a discarded frame leaves btn and counters unchanged, and frame_done still pulses.
REQ-026 SHALL, when IO_KEYPAD_GHOST_EN is undefined, process every frame per REQ-015/016 with no ghost check, and the check logic is absent from the netlist.

Verification
REQ-027 SHALL cover the basic press: SCAN_DIV=4, DEBOUNCE_FRAMES=3, hold key (col 2,row 1) from reset release -> btn[11] rises and btn_press[11] pulses at the third frame_done (cycle 60 after reset); no other bits change.
REQ-028 SHALL cover the bounce: same parameters, key 11 pressed for 2 frames, released 1 frame, pressed again -> btn[11] rises only after 3 further consecutive pressed frames; no earlier pulse.
REQ-029 SHALL cover the release: key 0 held until btn[0]=1, then released -> btn_release[0] pulses exactly once, 3 frames later; btn_press stays 0.
REQ-030 SHALL cover the scan order: observe btnx for 20 cycles after reset -> 11110 x4, 11101 x4, 11011 x4, 10111 x4, 01111 x4, then repeat.
REQ-031 SHALL cover reset mid-operation: assert rst_n=0 while column 3 is driven and key 24 is mid-debounce -> btnx=11110 and all outputs 0 immediately; after release, key 24 needs a full 3 frames.
REQ-032 SHALL cover ghost rejection: with IO_KEYPAD_GHOST_EN, press keys 0, 1 and 5 together -> btn stays 0; without the macro -> btn[0], btn[1] and btn[5] rise together.
